mult8_reversible: RTL and testbench

- Bidirectional 8x8 multiplier stage for the reversible pipeline (revPE).
- Forward direction (dir=0): computes the 16-bit product and passes operand A through.
- Backward direction (dir=1): recovers A, B and an "extra" byte from a product/A pair.
- One registered output stage; sits between adjacent reversible pipeline stages.

---
 rtl/mult8_rev_pkg.sv | 17 +
 rtl/div16_restoring.sv | 43 ++++
 rtl/mult8_reversible.sv | 101 ++++++++++
 tb/tb_mult8_reversible.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mult8_rev_pkg.sv
// -----------------------------------------------------------------------------
// mult8_rev_pkg
// Shared widths and direction encodings for the reversible 8x8 multiplier stage.
//   OP_W    : operand width (8)
//   PROD_W  : product / divider width (16)
//   DIR_FWD : dir value selecting the forward (multiply) path
//   DIR_BWD : dir value selecting the backward (divide) path
// -----------------------------------------------------------------------------
package mult8_rev_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

endpackage : mult8_rev_pkg

// File: rtl/div16_restoring.sv
// -----------------------------------------------------------------------------
// div16_restoring
// Combinational unsigned 16/16 restoring divider, fully unrolled so the whole
// quotient settles within one clock period.
// Ports:
//   dividend_i    [15:0] : numerator
//   divisor_i     [15:0] : denominator
//   quotient_o    [15:0] : floor(dividend / divisor); forced to 0 when divisor is 0
//   div_by_zero_o        : high when divisor_i == 0
// -----------------------------------------------------------------------------
module div16_restoring
    import mult8_rev_pkg::*;
(
    input  logic [PROD_W-1:0] dividend_i,
    input  logic [PROD_W-1:0] divisor_i,
    output logic [PROD_W-1:0] quotient_o,
    output logic              div_by_zero_o
);

    logic [PROD_W:0]   rem;
    logic [PROD_W-1:0] quo;

    // One shift/compare/subtract step per quotient bit, MSB first. The partial
    // remainder carries one extra bit so the shifted value can never overflow
    // before the comparison against the divisor.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = PROD_W - 1; i >= 0; i--) begin
            rem = {rem[PROD_W-1:0], dividend_i[i]};
            if (rem >= {1'b0, divisor_i}) begin
                rem    = rem - {1'b0, divisor_i};
                quo[i] = 1'b1;
            end
        end
    end

    assign div_by_zero_o = (divisor_i == '0);

    // A zero divisor would otherwise yield an all-ones quotient.
    assign quotient_o = div_by_zero_o ? '0 : quo;

endmodule : div16_restoring

// File: rtl/mult8_reversible.sv
// -----------------------------------------------------------------------------
// mult8_reversible
// Bidirectional 8x8 multiplier stage for the reversible pipeline. One registered
// output stage, 1-cycle latency, no handshake.
// Ports:
//   clk            : clock, outputs update on rising edge
//   rst_n          : asynchronous active-low reset, clears all outputs
//   dir            : 0 = forward (multiply), 1 = backward (divide)
//   f_a, f_b  [7:0]: forward operands
//   f_extra   [7:0]: reserved forward byte, has no effect
//   f_p      [15:0]: forward product f_a * f_b
//   f_a_b     [7:0]: forward pass-through of f_a
//   r_p      [15:0]: backward product; upper byte carries the extra byte
//   r_a_b    [15:0]: backward pass-through A, used whole as the divisor
//   r_a       [7:0]: recovered A (r_a_b[7:0])
//   r_b       [7:0]: recovered B (low byte of r_p / r_a_b, 0 on divide by zero)
//   r_extra   [7:0]: recovered extra byte (r_p[15:8])
// The outputs of the direction not selected are zeroed on every edge.
// -----------------------------------------------------------------------------
module mult8_reversible
    import mult8_rev_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dir,
    input  logic [OP_W-1:0]   f_a,
    input  logic [OP_W-1:0]   f_b,
    input  logic [OP_W-1:0]   f_extra,
    output logic [PROD_W-1:0] f_p,
    output logic [OP_W-1:0]   f_a_b,
    input  logic [PROD_W-1:0] r_p,
    input  logic [PROD_W-1:0] r_a_b,
    output logic [OP_W-1:0]   r_a,
    output logic [OP_W-1:0]   r_b,
    output logic [OP_W-1:0]   r_extra
);

    logic [PROD_W-1:0] f_p_d,     f_p_q;
    logic [OP_W-1:0]   f_a_b_d,   f_a_b_q;
    logic [OP_W-1:0]   r_a_d,     r_a_q;
    logic [OP_W-1:0]   r_b_d,     r_b_q;
    logic [OP_W-1:0]   r_extra_d, r_extra_q;

    logic [PROD_W-1:0] quotient;
    logic              div_by_zero;
    logic [PROD_W-1:0] product;

    div16_restoring u_div (
        .dividend_i    (r_p),
        .divisor_i     (r_a_b),
        .quotient_o    (quotient),
        .div_by_zero_o (div_by_zero)
    );

    // Operands are widened before multiplying so the full 16-bit product is kept.
    assign product = {{(PROD_W-OP_W){1'b0}}, f_a} * {{(PROD_W-OP_W){1'b0}}, f_b};

    // f_extra is reserved; the high quotient byte is dropped by design (truncation).
    logic unused_bits;
    assign unused_bits = ^{f_extra, quotient[PROD_W-1:OP_W]};

    always_comb begin
        f_p_d     = '0;
        f_a_b_d   = '0;
        r_a_d     = '0;
        r_b_d     = '0;
        r_extra_d = '0;
        if (dir == DIR_FWD) begin
            f_p_d   = product;
            f_a_b_d = f_a;
        end else begin
            r_a_d     = r_a_b[OP_W-1:0];
            r_b_d     = div_by_zero ? '0 : quotient[OP_W-1:0];
            r_extra_d = r_p[PROD_W-1:OP_W];
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_p_q     <= '0;
            f_a_b_q   <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_extra_q <= '0;
        end else begin
            f_p_q     <= f_p_d;
            f_a_b_q   <= f_a_b_d;
            r_a_q     <= r_a_d;
            r_b_q     <= r_b_d;
            r_extra_q <= r_extra_d;
        end
    end

    assign f_p     = f_p_q;
    assign f_a_b   = f_a_b_q;
    assign r_a     = r_a_q;
    assign r_b     = r_b_q;
    assign r_extra = r_extra_q;

endmodule : mult8_reversible

// File: tb/tb_mult8_reversible.sv
// -----------------------------------------------------------------------------
// tb_mult8_reversible
// Directed testbench for mult8_reversible with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mult8_reversible;

    logic        clk;
    logic        rst_n;
    logic        dir;
    logic [7:0]  f_a, f_b, f_extra;
    logic [15:0] f_p;
    logic [7:0]  f_a_b;
    logic [15:0] r_p, r_a_b;
    logic [7:0]  r_a, r_b, r_extra;

    int checks;
    int failures;

    mult8_reversible dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dir     (dir),
        .f_a     (f_a),
        .f_b     (f_b),
        .f_extra (f_extra),
        .f_p     (f_p),
        .f_a_b   (f_a_b),
        .r_p     (r_p),
        .r_a_b   (r_a_b),
        .r_a     (r_a),
        .r_b     (r_b),
        .r_extra (r_extra)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic [15:0] e_f_p, input logic [7:0] e_f_a_b,
                             input logic [7:0] e_r_a, input logic [7:0] e_r_b,
                             input logic [7:0] e_r_extra);
        check_val({tag, ".f_p"},     f_p,              e_f_p);
        check_val({tag, ".f_a_b"},   {8'h00, f_a_b},   {8'h00, e_f_a_b});
        check_val({tag, ".r_a"},     {8'h00, r_a},     {8'h00, e_r_a});
        check_val({tag, ".r_b"},     {8'h00, r_b},     {8'h00, e_r_b});
        check_val({tag, ".r_extra"}, {8'h00, r_extra}, {8'h00, e_r_extra});
    endtask

    // Drive at the falling edge, let one rising edge capture, sample at the next falling edge.
    task automatic run_fwd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] x, input logic [15:0] e_p, input logic [7:0] e_ab);
        dir = 1'b0; f_a = a; f_b = b; f_extra = x;
        r_p = 16'hA5C3; r_a_b = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        check_all(tag, e_p, e_ab, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic run_bwd(input string tag, input logic [15:0] p, input logic [15:0] ab,
                           input logic [7:0] e_a, input logic [7:0] e_b, input logic [7:0] e_x);
        dir = 1'b1; r_p = p; r_a_b = ab;
        f_a = 8'h3C; f_b = 8'h7E; f_extra = 8'h99;
        @(posedge clk);
        @(negedge clk);
        check_all(tag, 16'h0000, 8'h00, e_a, e_b, e_x);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with arbitrary inputs on both paths.
        rst_n = 1'b0;
        dir = 1'b0; f_a = 8'hFF; f_b = 8'hFF; f_extra = 8'h5A;
        r_p = 16'hFFFF; r_a_b = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset_hold", 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        run_fwd("fwd1",    8'h12, 8'h04, 8'hAA, 16'h0048, 8'h12);
        run_fwd("fwd2",    8'h08, 8'h11, 8'h55, 16'h0088, 8'h08);
        run_fwd("fwd_max", 8'hFF, 8'hFF, 8'h00, 16'hFE01, 8'hFF);
        run_fwd("fwd_zero", 8'h00, 8'hC7, 8'hFF, 16'h0000, 8'h00);

        // Switching direction zeroes the forward outputs in the same edge.
        run_bwd("bwd1",     16'h8C40, 16'h0012, 8'h12, 8'hCA, 8'h8C);
        run_bwd("bwd2",     16'h7740, 16'h0008, 8'h08, 8'hE8, 8'h77);
        run_bwd("bwd_div0", 16'h1234, 16'h0000, 8'h00, 8'h00, 8'h12);
        // 0xFFFF / 1 = 0xFFFF, truncated to 0xFF.
        run_bwd("bwd_div1", 16'hFFFF, 16'h0001, 8'h01, 8'hFF, 8'hFF);
        // Upper divisor byte matters: 65535 / 4660 = 14.
        run_bwd("bwd_wide", 16'hFFFF, 16'h1234, 8'h34, 8'h0E, 8'hFF);
        // Divisor larger than dividend.
        run_bwd("bwd_small", 16'h0010, 16'h0100, 8'h00, 8'h00, 8'h00);

        // Back to forward: the recovered outputs are zeroed.
        run_fwd("fwd_after_bwd", 8'h0F, 8'h10, 8'h01, 16'h00F0, 8'h0F);

        // Mid-run reset clears outputs without any clock edge.
        run_bwd("bwd_pre_rst", 16'h2050, 16'h0010, 8'h10, 8'h05, 8'h20);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // First valid result one edge after release.
        run_fwd("post_rst", 8'h03, 8'h05, 8'h77, 16'h000F, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule : tb_mult8_reversible
